// File: rtl/axil_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_ram_pkg
// Description : Shared types for the AXI4-Lite RAM slave. Holds the AXI
//               response encoding and the write/read channel state enums.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_ram_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PEND = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_PEND = 2'd1,
        R_DATA = 2'd2,
        R_RESP = 2'd3
    } rd_state_t;

endpackage : axil_ram_pkg
`default_nettype wire

// File: rtl/axil_ram_sp_ram_be.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_be
// Description : Single-port synchronous RAM with per-byte write enables.
//               Read latency one cycle, read-first: a read and a write to the
//               same word on the same edge return the old contents.
// Ports       : clk   - clock
//               en    - port enable (read and/or write this cycle)
//               we    - byte-lane write enables
//               addr  - word address
//               wdata - write data
//               rdata - registered read data
// Parameters  : WIDTH (multiple of 8), DEPTH (words), INIT_FILE (name of the
//               preload image handed to the memory build flow; the model
//               itself starts with undefined contents)
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_be #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [WIDTH/8-1:0]       we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    localparam int c_lanes = WIDTH / 8;

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= r_mem[addr];
            for (int i = 0; i < c_lanes; i++) begin
                if (we[i]) begin
                    r_mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule : sp_ram_be
`default_nettype wire

// File: rtl/axil_ram.sv
`default_nettype none
// ============================================================================
// Module      : axil_ram
// Description : AXI4-Lite slave backed by one single-port byte-writable RAM.
//               Independent write (AW+W -> B) and read (AR -> R) channels,
//               one outstanding transaction each, share the RAM port through
//               an alternating arbiter. Misaligned or out-of-range accesses
//               are answered with SLVERR and never touch the RAM.
// Ports       : clk, rst (synchronous, active-high)
//               s_aw*/s_w*/s_b* - AXI4-Lite write address/data/response
//               s_ar*/s_r*      - AXI4-Lite read address/data
//               s_awprot/s_arprot are accepted and ignored.
// Latency     : AW+W handshake at N -> bvalid at N+2
//               AR handshake at N   -> rvalid at N+3 (no arbitration conflict)
// Revision    : 1.0 - initial release
// ============================================================================
module axil_ram
    import axil_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_WORDS  = 1024,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [2:0]            s_awprot,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [STRB_WIDTH-1:0] s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [2:0]            s_arprot,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready
);

    localparam int c_addr_lsb = $clog2(STRB_WIDTH);
    localparam int c_ram_aw   = $clog2(MEM_WORDS);
    localparam int c_idx_w    = ADDR_WIDTH - c_addr_lsb;
    // One extra bit so MEM_WORDS itself is representable for the range check.
    localparam logic [c_idx_w:0] c_mem_words = (c_idx_w + 1)'(MEM_WORDS);

    function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] addr);
        logic [c_idx_w:0] idx;
        idx = {1'b0, addr[ADDR_WIDTH-1:c_addr_lsb]};
        return (addr[c_addr_lsb-1:0] == '0) && (idx < c_mem_words);
    endfunction

    // ---------------------------------------------------------------- state
    wr_state_t r_wr_state, w_wr_state_nxt;
    rd_state_t r_rd_state, w_rd_state_nxt;

    logic                  r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    resp_t                 r_bresp, r_rresp;
    logic                  r_last_rd;   // 1: read was the last side granted

    logic                  w_aw_hs, w_w_hs, w_ar_hs;
    logic                  w_wr_req, w_rd_req, w_grant_wr, w_grant_rd;
    logic                  w_wr_legal, w_rd_legal;
    logic                  w_ram_en;
    logic [STRB_WIDTH-1:0] w_ram_we;
    logic [c_ram_aw-1:0]   w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    logic                  w_unused_prot;

    assign w_unused_prot = ^{s_awprot, s_arprot};

    // ------------------------------------------------------ channel handshakes
    // Readys are held low during reset so nothing is accepted on the reset edge.
    assign s_awready = !rst && (r_wr_state == W_IDLE) && !r_aw_held;
    assign s_wready  = !rst && (r_wr_state == W_IDLE) && !r_w_held;
    assign s_arready = !rst && (r_rd_state == R_IDLE);

    assign w_aw_hs = s_awvalid && s_awready;
    assign w_w_hs  = s_wvalid  && s_wready;
    assign w_ar_hs = s_arvalid && s_arready;

    assign s_bvalid = (r_wr_state == W_RESP);
    assign s_bresp  = r_bresp;
    assign s_rvalid = (r_rd_state == R_RESP);
    assign s_rdata  = r_rdata;
    assign s_rresp  = r_rresp;

    // --------------------------------------------------------------- arbiter
    assign w_wr_req   = (r_wr_state == W_PEND);
    assign w_rd_req   = (r_rd_state == R_PEND);
    assign w_grant_wr = w_wr_req && (!w_rd_req || r_last_rd);
    assign w_grant_rd = w_rd_req && (!w_wr_req || !r_last_rd);

    assign w_wr_legal = addr_legal(r_awaddr);
    assign w_rd_legal = addr_legal(r_araddr);

    // Illegal accesses still consume their grant cycle but leave the RAM idle.
    // The rst term keeps a grant coinciding with reset from writing the array.
    assign w_ram_en   = !rst && ((w_grant_wr && w_wr_legal) || (w_grant_rd && w_rd_legal));
    assign w_ram_we   = (!rst && w_grant_wr && w_wr_legal) ? r_wstrb : '0;
    assign w_ram_addr = w_grant_wr ? r_awaddr[c_addr_lsb +: c_ram_aw]
                                   : r_araddr[c_addr_lsb +: c_ram_aw];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_rd <= 1'b1;
        end else if (w_grant_wr) begin
            r_last_rd <= 1'b0;
        end else if (w_grant_rd) begin
            r_last_rd <= 1'b1;
        end
    end

    // ------------------------------------------------------------ write FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_rd_state <= R_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_rd_state_nxt = r_rd_state;

        case (r_wr_state)
            W_IDLE: if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) w_wr_state_nxt = W_PEND;
            W_PEND: if (w_grant_wr) w_wr_state_nxt = W_RESP;
            W_RESP: if (s_bready)   w_wr_state_nxt = W_IDLE;
            default:                w_wr_state_nxt = W_IDLE;
        endcase

        case (r_rd_state)
            R_IDLE: if (w_ar_hs)    w_rd_state_nxt = R_PEND;
            R_PEND: if (w_grant_rd) w_rd_state_nxt = R_DATA;
            R_DATA:                 w_rd_state_nxt = R_RESP;
            R_RESP: if (s_rready)   w_rd_state_nxt = R_IDLE;
            default:                w_rd_state_nxt = R_IDLE;
        endcase
    end

    // --------------------------------------------------------- write capture
    // AW and W are latched independently; the held flags stay set until the
    // B handshake so the readys remain low for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_wdata;
                r_wstrb  <= s_wstrb;
            end
            if (w_grant_wr) begin
                r_bresp <= w_wr_legal ? OKAY : SLVERR;
            end
            if (s_bvalid && s_bready) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------- read capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_araddr <= '0;
            r_rdata  <= '0;
            r_rresp  <= OKAY;
        end else begin
            if (w_ar_hs) begin
                r_araddr <= s_araddr;
            end
            if (r_rd_state == R_DATA) begin
                r_rdata <= w_rd_legal ? w_ram_rdata : '0;
                r_rresp <= w_rd_legal ? OKAY : SLVERR;
            end
        end
    end

    // ------------------------------------------------------------------ RAM
    sp_ram_be #(
        .WIDTH     (DATA_WIDTH),
        .DEPTH     (MEM_WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (w_ram_en),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

endmodule : axil_ram
`default_nettype wire

// File: tb/tb_axil_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_ram
// Description : Directed, table-driven bench for axil_ram with hand-written
//               sequences for arbitration, stalls and reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_ram;

    logic        clk, rst;
    logic [15:0] s_awaddr, s_araddr;
    logic [2:0]  s_awprot, s_arprot;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic [31:0] s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;

    int checks   = 0;
    int failures = 0;

    axil_ram dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // AW and W presented together; returns bresp and cycles from handshake to bvalid.
    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output int lat);
        int k;
        @(negedge clk);
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        k = 0;
        while (!(s_awready && s_wready) && k < 20) begin @(negedge clk); k++; end
        check("wr_accept", {31'd0, s_awready && s_wready}, 32'd1);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!s_bvalid && lat < 30);
        check("wr_bvalid", {31'd0, s_bvalid}, 32'd1);
        resp = s_bresp;
        @(posedge clk); #1;
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        int k;
        @(negedge clk);
        s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
        k = 0;
        while (!s_arready && k < 20) begin @(negedge clk); k++; end
        check("rd_accept", {31'd0, s_arready}, 32'd1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!s_rvalid && lat < 30);
        check("rd_rvalid", {31'd0, s_rvalid}, 32'd1);
        data = s_rdata;
        resp = s_rresp;
        @(posedge clk); #1;
        s_rready = 1'b0;
    endtask

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    logic [1:0]  br, rr;
    logic [31:0] rd;
    int          lb, lr;

    initial begin
        vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 16'h0010, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 16'h0000, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 16'h1000, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
        vecs[4]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
        vecs[5]  = '{1'b0, 16'h0012, 32'h0,        4'h0, 2'b10, 32'h0};
        vecs[6]  = '{1'b0, 16'h1000, 32'h0,        4'h0, 2'b10, 32'h0};
        vecs[7]  = '{1'b1, 16'h0004, 32'h12345678, 4'hF, 2'b00, 32'h0};
        vecs[8]  = '{1'b1, 16'h0004, 32'hAABBCCDD, 4'h6, 2'b00, 32'h0};
        vecs[9]  = '{1'b0, 16'h0004, 32'h0,        4'h0, 2'b00, 32'h12BBCC78};
        vecs[10] = '{1'b1, 16'h0004, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 16'h0004, 32'h0,        4'h0, 2'b00, 32'h12BBCC78};
        vecs[12] = '{1'b1, 16'h0006, 32'h0000FFFF, 4'hF, 2'b10, 32'h0};
        vecs[13] = '{1'b0, 16'h0004, 32'h0,        4'h0, 2'b00, 32'h12BBCC78};
        vecs[14] = '{1'b0, 16'hFFFC, 32'h0,        4'h0, 2'b10, 32'h0};
        vecs[15] = '{1'b1, 16'h0FFC, 32'h0BADC0DE, 4'hF, 2'b00, 32'h0};
        vecs[16] = '{1'b0, 16'h0FFC, 32'h0,        4'h0, 2'b00, 32'h0BADC0DE};

        rst = 1'b1;
        s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0; s_rready = 1'b0;

        // ---- reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {27'd0, s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 32'd0);
        check("reset_resp", {28'd0, s_bresp, s_rresp}, 32'd0);
        check("reset_rdata", s_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_readys", {29'd0, s_awready, s_wready, s_arready}, 32'd7);

        // ---- table-driven single transactions
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, br, lb);
                check($sformatf("vec%0d_bresp", i), {30'd0, br}, {30'd0, vecs[i].exp_resp});
                check($sformatf("vec%0d_blat", i), lb, 32'd2);
            end else begin
                axi_read(vecs[i].addr, rd, rr, lr);
                check($sformatf("vec%0d_rresp", i), {30'd0, rr}, {30'd0, vecs[i].exp_resp});
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
                check($sformatf("vec%0d_rlat", i), lr, 32'd3);
            end
        end

        // ---- W first, AW three cycles later
        begin
            int k;
            @(negedge clk);
            s_wdata = 32'h000000AA; s_wstrb = 4'h1; s_wvalid = 1'b1; s_bready = 1'b1;
            k = 0;
            while (!s_wready && k < 20) begin @(negedge clk); k++; end
            check("wfirst_wready", {31'd0, s_wready}, 32'd1);
            @(posedge clk); #1;
            s_wvalid = 1'b0;
            @(negedge clk);
            check("wfirst_held", {29'd0, s_awready, s_wready, s_bvalid}, 32'h4);
            @(negedge clk);
            @(negedge clk);
            s_awaddr = 16'h0010; s_awvalid = 1'b1;
            check("wfirst_awready", {31'd0, s_awready}, 32'd1);
            @(posedge clk); #1;
            s_awvalid = 1'b0;
            lb = 0;
            do begin @(negedge clk); lb++; end while (!s_bvalid && lb < 30);
            check("wfirst_blat", lb, 32'd2);
            check("wfirst_bresp", {30'd0, s_bresp}, 32'd0);
            @(posedge clk); #1;
            s_bready = 1'b0;
            axi_read(16'h0010, rd, rr, lr);
            check("wfirst_rdata", rd, 32'hDEADBEAA);
        end

        // ---- simultaneous write/read from reset: write granted first each pair
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] a;
            logic [31:0] d;
            a = 16'h0100 + 16'(i * 4);
            d = 32'hA5000000 | 32'(i);
            fork
                axi_write(a, d, 4'hF, br, lb);
                axi_read(a, rd, rr, lr);
            join
            check($sformatf("arb%0d_blat", i), lb, 32'd2);
            check($sformatf("arb%0d_rlat", i), lr, 32'd4);
            check($sformatf("arb%0d_rdata", i), rd, d);
        end

        // ---- bready held low: write channel stalls, reads keep flowing
        begin
            int k;
            @(negedge clk);
            s_awaddr = 16'h0020; s_wdata = 32'h5A5A5A5A; s_wstrb = 4'hF;
            s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
            k = 0;
            while (!(s_awready && s_wready) && k < 20) begin @(negedge clk); k++; end
            @(posedge clk); #1;
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("stall_bvalid", {31'd0, s_bvalid}, 32'd1);
            axi_read(16'h0010, rd, rr, lr);
            check("stall_rdata", rd, 32'hDEADBEAA);
            check("stall_rlat", lr, 32'd3);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check($sformatf("stall_hold%0d", c),
                      {28'd0, s_bvalid, s_bresp, s_awready}, {28'd0, 1'b1, 2'b00, 1'b0});
            end
            s_bready = 1'b1;
            @(posedge clk); #1;
            s_bready = 1'b0;
            @(negedge clk);
            check("stall_release", {31'd0, s_bvalid}, 32'd0);
            axi_read(16'h0020, rd, rr, lr);
            check("stall_wdata", rd, 32'h5A5A5A5A);
        end

        // ---- reset asserted on the write grant cycle
        axi_write(16'h0200, 32'h11111111, 4'hF, br, lb);
        begin
            int k;
            @(negedge clk);
            s_awaddr = 16'h0200; s_wdata = 32'h22222222; s_wstrb = 4'hF;
            s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
            k = 0;
            while (!(s_awready && s_wready) && k < 20) begin @(negedge clk); k++; end
            @(posedge clk); #1;
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check("rstmid_valids", {30'd0, s_bvalid, s_rvalid}, 32'd0);
            check("rstmid_awready", {31'd0, s_awready}, 32'd1);
            axi_read(16'h0200, rd, rr, lr);
            check("rstmid_rdata", rd, 32'h11111111);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_axil_ram
`default_nettype wire
